// File: rtl/timer_pkg.sv
// Shared definitions for the PWM timer sequencer.
//   DW          : timer data width
//   TMR_*       : timer register addresses, also used as profile field selects
//   state_e     : sequencer FSM states
package timer_pkg;

  localparam int unsigned DW = 16;

  localparam logic [1:0] TMR_MAX     = 2'd0;
  localparam logic [1:0] TMR_PWM     = 2'd1;
  localparam logic [1:0] TMR_STOP    = 2'd2;
  localparam logic [1:0] TMR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_START,
    ST_WAIT_END,
    ST_WAIT_CLR,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/timer_prof_table.sv
// Profile table: N_ENTRY entries of {max, pwm, stop}, each DW bits.
//   clk_i    : clock
//   we_i     : write strobe (already qualified by the caller)
//   widx_i   : entry to write
//   field_i  : field to write (TMR_MAX/TMR_PWM/TMR_STOP; other codes ignored)
//   wdata_i  : write data
//   ridx_i   : entry to read (combinational)
//   max_o/pwm_o/stop_o : fields of the entry selected by ridx_i
// Contents are deliberately not reset.
module timer_prof_table
  import timer_pkg::*;
#(
  parameter int unsigned N_ENTRY = 4,
  parameter int unsigned IW      = 2,
  parameter int unsigned DW      = timer_pkg::DW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [1:0]    field_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [DW-1:0] max_o,
  output logic [DW-1:0] pwm_o,
  output logic [DW-1:0] stop_o
);

  logic [DW-1:0] max_q  [N_ENTRY];
  logic [DW-1:0] pwm_q  [N_ENTRY];
  logic [DW-1:0] stop_q [N_ENTRY];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (field_i)
        TMR_MAX:  max_q[widx_i]  <= wdata_i;
        TMR_PWM:  pwm_q[widx_i]  <= wdata_i;
        TMR_STOP: stop_q[widx_i] <= wdata_i;
        default:  ;
      endcase
    end
  end

  assign max_o  = max_q[ridx_i];
  assign pwm_o  = pwm_q[ridx_i];
  assign stop_o = stop_q[ridx_i];

endmodule

// File: rtl/timer_seq_ctrl.sv
// Sequencer driving one PWM timer's register port from a profile table.
// Ports:
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_cfg_we/idx/field/wdata       : host profile-table write port (IDLE only)
//   i_run                          : rising edge starts, low aborts
//   i_loop, i_last_idx             : sequence shape, sampled at start
//   o_tmr_we/addr/wdata/start      : timer register port and start level
//   i_tmr_end                      : timer end flag
//   o_busy, o_step_idx             : status
//   o_step_done, o_seq_done        : completion pulses
//   o_cfg_err                      : rejected config write pulse
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned N_ENTRY = 4,
  parameter int unsigned IW      = 2,
  parameter int unsigned DW      = timer_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [1:0]    i_cfg_field,
  input  logic [DW-1:0] i_cfg_wdata,
  input  logic          i_run,
  input  logic          i_loop,
  input  logic [IW-1:0] i_last_idx,
  output logic          o_tmr_we,
  output logic [1:0]    o_tmr_addr,
  output logic [DW-1:0] o_tmr_wdata,
  output logic          o_tmr_start,
  input  logic          i_tmr_end,
  output logic          o_busy,
  output logic [IW-1:0] o_step_idx,
  output logic          o_step_done,
  output logic          o_seq_done,
  output logic          o_cfg_err
);

  state_e        state_q, state_d;
  logic          run_q;
  logic [IW-1:0] step_q, step_d;
  logic [IW-1:0] last_q, last_d;
  logic          loop_q, loop_d;
  logic [1:0]    ld_cnt_q, ld_cnt_d;
  logic          cfg_err_q;

  logic          run_rise;
  logic          busy;
  logic          cfg_ok;
  logic [DW-1:0] ent_max, ent_pwm, ent_stop;

  assign busy     = (state_q != ST_IDLE);
  assign run_rise = i_run & ~run_q;
  assign cfg_ok   = i_cfg_we & ~busy & (i_cfg_field != TMR_ILLEGAL);

  timer_prof_table #(
    .N_ENTRY (N_ENTRY),
    .IW      (IW),
    .DW      (DW)
  ) u_table (
    .clk_i   (i_clk),
    .we_i    (cfg_ok),
    .widx_i  (i_cfg_idx),
    .field_i (i_cfg_field),
    .wdata_i (i_cfg_wdata),
    .ridx_i  (step_q),
    .max_o   (ent_max),
    .pwm_o   (ent_pwm),
    .stop_o  (ent_stop)
  );

  // run_q resets high so a run level held through reset does not start a
  // sequence; a fresh low-to-high transition is required.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b1;
      step_q    <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      ld_cnt_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= i_run;
      step_q    <= step_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      ld_cnt_q  <= ld_cnt_d;
      cfg_err_q <= i_cfg_we & ~cfg_ok;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_d      = last_q;
    loop_d      = loop_q;
    ld_cnt_d    = ld_cnt_q;
    o_tmr_we    = 1'b0;
    o_tmr_addr  = '0;
    o_tmr_wdata = '0;
    o_tmr_start = 1'b0;
    o_step_done = 1'b0;
    o_seq_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_rise) begin
          step_d  = '0;
          last_d  = i_last_idx;
          loop_d  = i_loop;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ld_cnt_d = '0;
        state_d  = (ent_max == '0) ? ST_NEXT : ST_LOAD;
      end
      ST_LOAD: begin
        // ld_cnt_q doubles as the timer register address
        o_tmr_we   = 1'b1;
        o_tmr_addr = ld_cnt_q;
        case (ld_cnt_q)
          TMR_MAX: o_tmr_wdata = ent_max;
          TMR_PWM: o_tmr_wdata = ent_pwm;
          default: o_tmr_wdata = ent_stop;
        endcase
        if (ld_cnt_q == TMR_STOP) begin
          ld_cnt_d = '0;
          state_d  = ST_START;
        end else begin
          ld_cnt_d = ld_cnt_q + 2'd1;
        end
      end
      ST_START: begin
        o_tmr_start = 1'b1;
        state_d     = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        o_tmr_start = 1'b1;
        if (i_tmr_end) state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!i_tmr_end) begin
          o_step_done = 1'b1;
          state_d     = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (step_q != last_q) begin
          step_d  = step_q + 1'b1;
          state_d = ST_CHECK;
        end else if (loop_q) begin
          step_d  = '0;
          state_d = ST_CHECK;
        end else begin
          o_seq_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort: return to IDLE next cycle; completion pulses are suppressed.
    if (busy && !i_run) begin
      state_d     = ST_IDLE;
      ld_cnt_d    = '0;
      o_step_done = 1'b0;
      o_seq_done  = 1'b0;
    end
  end

  assign o_busy     = busy;
  assign o_step_idx = step_q;
  assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
module tb_timer_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_idx;
  logic [1:0]  i_cfg_field;
  logic [15:0] i_cfg_wdata;
  logic        i_run;
  logic        i_loop;
  logic [1:0]  i_last_idx;
  logic        o_tmr_we;
  logic [1:0]  o_tmr_addr;
  logic [15:0] o_tmr_wdata;
  logic        o_tmr_start;
  logic        i_tmr_end;
  logic        o_busy;
  logic [1:0]  o_step_idx;
  logic        o_step_done;
  logic        o_seq_done;
  logic        o_cfg_err;

  int checks   = 0;
  int failures = 0;

  timer_seq_ctrl #(.N_ENTRY(4), .IW(2), .DW(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_idx   (i_cfg_idx),
    .i_cfg_field (i_cfg_field),
    .i_cfg_wdata (i_cfg_wdata),
    .i_run       (i_run),
    .i_loop      (i_loop),
    .i_last_idx  (i_last_idx),
    .o_tmr_we    (o_tmr_we),
    .o_tmr_addr  (o_tmr_addr),
    .o_tmr_wdata (o_tmr_wdata),
    .o_tmr_start (o_tmr_start),
    .i_tmr_end   (i_tmr_end),
    .o_busy      (o_busy),
    .o_step_idx  (o_step_idx),
    .o_step_done (o_step_done),
    .o_seq_done  (o_seq_done),
    .o_cfg_err   (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] fld, input logic [15:0] d);
    i_cfg_we = 1'b1; i_cfg_idx = idx; i_cfg_field = fld; i_cfg_wdata = d;
    tick;
    i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_field = '0; i_cfg_wdata = '0;
  endtask

  // Leaves the FSM in its first CHECK cycle.
  task automatic start_run;
    i_run = 1'b0;
    tick;
    i_run = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL run_edge_idle busy=%b exp=0", o_busy); end
    tick;
  endtask

  // Executes one valid entry from its CHECK cycle through NEXT; ends in the following cycle.
  task automatic run_step(input int idx, input logic [15:0] mx, input logic [15:0] pw,
                          input logic [15:0] st, input logic exp_seq);
    logic [1:0] eidx;
    eidx = idx[1:0];
    checks++;
    if (o_step_idx !== eidx || o_tmr_we !== 1'b0 || o_busy !== 1'b1) begin
      failures++; $display("FAIL step_check idx=%0d we=%b busy=%b exp idx=%0d we=0 busy=1", o_step_idx, o_tmr_we, o_busy, eidx);
    end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd0 || o_tmr_wdata !== mx) begin
      failures++; $display("FAIL step_wr_max we=%b addr=%0d data=%0d exp 1/0/%0d", o_tmr_we, o_tmr_addr, o_tmr_wdata, mx);
    end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd1 || o_tmr_wdata !== pw) begin
      failures++; $display("FAIL step_wr_pwm we=%b addr=%0d data=%0d exp 1/1/%0d", o_tmr_we, o_tmr_addr, o_tmr_wdata, pw);
    end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd2 || o_tmr_wdata !== st) begin
      failures++; $display("FAIL step_wr_stop we=%b addr=%0d data=%0d exp 1/2/%0d", o_tmr_we, o_tmr_addr, o_tmr_wdata, st);
    end
    tick;
    checks++;
    if (o_tmr_start !== 1'b1 || o_tmr_we !== 1'b0 || o_tmr_wdata !== 16'd0) begin
      failures++; $display("FAIL step_start start=%b we=%b data=%0d exp 1/0/0", o_tmr_start, o_tmr_we, o_tmr_wdata);
    end
    tick;
    i_tmr_end = 1'b1;
    #1;
    checks++;
    if (o_tmr_start !== 1'b1) begin failures++; $display("FAIL step_wait_end start=%b exp=1", o_tmr_start); end
    tick;
    checks++;
    if (o_tmr_start !== 1'b0 || o_step_done !== 1'b0) begin
      failures++; $display("FAIL step_wait_clr start=%b done=%b exp 0/0", o_tmr_start, o_step_done);
    end
    tick;
    i_tmr_end = 1'b0;
    #1;
    checks++;
    if (o_step_done !== 1'b1) begin failures++; $display("FAIL step_done got=%b exp=1", o_step_done); end
    tick;
    checks++;
    if (o_seq_done !== exp_seq || o_step_done !== 1'b0) begin
      failures++; $display("FAIL step_next seq_done=%b step_done=%b exp %b/0", o_seq_done, o_step_done, exp_seq);
    end
    tick;
    checks++;
    if (o_busy !== !exp_seq || o_seq_done !== 1'b0) begin
      failures++; $display("FAIL step_after busy=%b seq_done=%b exp %b/0", o_busy, o_seq_done, !exp_seq);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_field = '0; i_cfg_wdata = '0;
    i_run = 1'b0; i_loop = 1'b0; i_last_idx = '0; i_tmr_end = 1'b0;
    tick; tick;
    checks++;
    if ({o_tmr_we, o_tmr_addr, o_tmr_wdata, o_tmr_start, o_busy, o_step_idx, o_step_done, o_seq_done, o_cfg_err} !== '0) begin
      failures++; $display("FAIL reset_outputs we=%b addr=%0d data=%0d start=%b busy=%b idx=%0d exp all 0",
                           o_tmr_we, o_tmr_addr, o_tmr_wdata, o_tmr_start, o_busy, o_step_idx);
    end
    i_rst_n = 1'b1;
    tick; tick;
  endtask

  task automatic test_single;
    cfg_write(2'd0, 2'd0, 16'd10);
    cfg_write(2'd0, 2'd1, 16'd4);
    cfg_write(2'd0, 2'd2, 16'd2);
    i_last_idx = 2'd0; i_loop = 1'b0;
    start_run;
    checks++;
    if (o_busy !== 1'b1 || o_tmr_we !== 1'b0) begin failures++; $display("FAIL single_check busy=%b we=%b exp 1/0", o_busy, o_tmr_we); end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd0 || o_tmr_wdata !== 16'd10) begin
      failures++; $display("FAIL single_wr0 we=%b addr=%0d data=%0d exp 1/0/10", o_tmr_we, o_tmr_addr, o_tmr_wdata);
    end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd1 || o_tmr_wdata !== 16'd4) begin
      failures++; $display("FAIL single_wr1 we=%b addr=%0d data=%0d exp 1/1/4", o_tmr_we, o_tmr_addr, o_tmr_wdata);
    end
    tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd2 || o_tmr_wdata !== 16'd2) begin
      failures++; $display("FAIL single_wr2 we=%b addr=%0d data=%0d exp 1/2/2", o_tmr_we, o_tmr_addr, o_tmr_wdata);
    end
    tick;
    checks++;
    if (o_tmr_start !== 1'b1 || o_tmr_we !== 1'b0 || o_tmr_addr !== 2'd0) begin
      failures++; $display("FAIL single_start start=%b we=%b addr=%0d exp 1/0/0", o_tmr_start, o_tmr_we, o_tmr_addr);
    end
    tick; tick;
    checks++;
    if (o_tmr_start !== 1'b1) begin failures++; $display("FAIL single_hold start=%b exp=1", o_tmr_start); end
    i_tmr_end = 1'b1;
    tick;
    checks++;
    if (o_tmr_start !== 1'b0) begin failures++; $display("FAIL single_start_fall start=%b exp=0", o_tmr_start); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (o_step_done !== 1'b0 || o_busy !== 1'b1) begin
        failures++; $display("FAIL single_clr_wait cyc=%0d done=%b busy=%b exp 0/1", c, o_step_done, o_busy);
      end
      tick;
    end
    i_tmr_end = 1'b0;
    #1;
    checks++;
    if (o_step_done !== 1'b1 || o_seq_done !== 1'b0) begin
      failures++; $display("FAIL single_step_done step=%b seq=%b exp 1/0", o_step_done, o_seq_done);
    end
    tick;
    checks++;
    if (o_seq_done !== 1'b1 || o_step_done !== 1'b0) begin
      failures++; $display("FAIL single_seq_done seq=%b step=%b exp 1/0", o_seq_done, o_step_done);
    end
    tick;
    checks++;
    if (o_busy !== 1'b0 || o_seq_done !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b seq=%b exp 0/0", o_busy, o_seq_done); end
  endtask

  task automatic test_loop_abort;
    for (int e = 0; e < 4; e++) begin
      cfg_write(e[1:0], 2'd0, 16'(100 + e));
      cfg_write(e[1:0], 2'd1, 16'(40 + e));
      cfg_write(e[1:0], 2'd2, 16'd2);
    end
    i_last_idx = 2'd3; i_loop = 1'b1;
    start_run;
    for (int s = 0; s < 5; s++) run_step(s % 4, 16'(100 + s % 4), 16'(40 + s % 4), 16'd2, 1'b0);
    checks++;
    if (o_step_idx !== 2'd1) begin failures++; $display("FAIL loop_idx idx=%0d exp=1", o_step_idx); end
    tick; tick; tick; tick; tick;
    checks++;
    if (o_tmr_start !== 1'b1) begin failures++; $display("FAIL abort_pre start=%b exp=1", o_tmr_start); end
    i_run = 1'b0;
    #1;
    checks++;
    if (o_step_done !== 1'b0 || o_seq_done !== 1'b0) begin failures++; $display("FAIL abort_pulse step=%b seq=%b exp 0/0", o_step_done, o_seq_done); end
    tick;
    checks++;
    if (o_busy !== 1'b0 || o_tmr_start !== 1'b0 || o_tmr_we !== 1'b0) begin
      failures++; $display("FAIL abort_idle busy=%b start=%b we=%b exp 0/0/0", o_busy, o_tmr_start, o_tmr_we);
    end
    tick;
    checks++;
    if (o_step_done !== 1'b0 || o_seq_done !== 1'b0) begin failures++; $display("FAIL abort_after step=%b seq=%b exp 0/0", o_step_done, o_seq_done); end
  endtask

  task automatic test_skip;
    cfg_write(2'd1, 2'd0, 16'd0);
    i_last_idx = 2'd2; i_loop = 1'b0;
    start_run;
    run_step(0, 16'd100, 16'd40, 16'd2, 1'b0);
    checks++;
    if (o_step_idx !== 2'd1 || o_tmr_we !== 1'b0) begin failures++; $display("FAIL skip_check idx=%0d we=%b exp 1/0", o_step_idx, o_tmr_we); end
    tick;
    checks++;
    if (o_tmr_we !== 1'b0 || o_step_done !== 1'b0 || o_seq_done !== 1'b0 || o_tmr_start !== 1'b0) begin
      failures++; $display("FAIL skip_next we=%b step=%b seq=%b start=%b exp all 0", o_tmr_we, o_step_done, o_seq_done, o_tmr_start);
    end
    tick;
    run_step(2, 16'd102, 16'd42, 16'd2, 1'b1);
  endtask

  task automatic test_cfg_err;
    cfg_write(2'd0, 2'd0, 16'd0);
    i_last_idx = 2'd2; i_loop = 1'b0;
    start_run;
    i_cfg_we = 1'b1; i_cfg_idx = 2'd2; i_cfg_field = 2'd0; i_cfg_wdata = 16'd99;
    tick;
    i_cfg_we = 1'b0;
    checks++;
    if (o_cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_busy got=%b exp=1", o_cfg_err); end
    tick;
    checks++;
    if (o_cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse got=%b exp=0", o_cfg_err); end
    tick; tick; tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_wdata !== 16'd102 || o_step_idx !== 2'd2) begin
      failures++; $display("FAIL cfg_table_kept we=%b data=%0d idx=%0d exp 1/102/2", o_tmr_we, o_tmr_wdata, o_step_idx);
    end
    i_run = 1'b0;
    tick;
    cfg_write(2'd0, 2'd3, 16'd5);
    checks++;
    if (o_cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_field3 got=%b exp=1", o_cfg_err); end
    cfg_write(2'd0, 2'd0, 16'd10);
    checks++;
    if (o_cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_ok_noerr got=%b exp=0", o_cfg_err); end
  endtask

  task automatic test_reset_load;
    i_last_idx = 2'd0; i_loop = 1'b0;
    start_run;
    tick; tick;
    checks++;
    if (o_tmr_we !== 1'b1 || o_tmr_addr !== 2'd1) begin failures++; $display("FAIL rst_pre we=%b addr=%0d exp 1/1", o_tmr_we, o_tmr_addr); end
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tmr_we, o_tmr_addr, o_tmr_wdata, o_tmr_start, o_busy, o_step_idx, o_step_done, o_seq_done, o_cfg_err} !== '0) begin
      failures++; $display("FAIL rst_async we=%b addr=%0d data=%0d busy=%b exp all 0", o_tmr_we, o_tmr_addr, o_tmr_wdata, o_busy);
    end
    tick; tick;
    i_rst_n = 1'b1;
    tick; tick;
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_needs_edge busy=%b exp=0", o_busy); end
    start_run;
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL rst_restart busy=%b exp=1", o_busy); end
    i_run = 1'b0;
    tick;
  endtask

  task automatic test_end_high;
    i_last_idx = 2'd0; i_loop = 1'b0;
    start_run;
    tick; tick; tick; tick;
    i_tmr_end = 1'b1;
    #1;
    checks++;
    if (o_tmr_start !== 1'b1) begin failures++; $display("FAIL endhi_start start=%b exp=1", o_tmr_start); end
    tick;
    checks++;
    if (o_tmr_start !== 1'b1) begin failures++; $display("FAIL endhi_wait_end start=%b exp=1", o_tmr_start); end
    tick;
    checks++;
    if (o_tmr_start !== 1'b0 || o_step_done !== 1'b0) begin failures++; $display("FAIL endhi_clr start=%b done=%b exp 0/0", o_tmr_start, o_step_done); end
    tick;
    checks++;
    if (o_step_done !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL endhi_hold done=%b busy=%b exp 0/1", o_step_done, o_busy); end
    i_tmr_end = 1'b0;
    #1;
    checks++;
    if (o_step_done !== 1'b1) begin failures++; $display("FAIL endhi_done got=%b exp=1", o_step_done); end
    tick;
    checks++;
    if (o_seq_done !== 1'b1) begin failures++; $display("FAIL endhi_seq got=%b exp=1", o_seq_done); end
    tick;
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL endhi_idle busy=%b exp=0", o_busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_loop_abort;
    test_skip;
    test_cfg_err;
    test_reset_load;
    test_end_high;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Sequencer that drives the PWM timer's register port from a small on-chip profile table.
- Host preloads N_ENTRY profiles, each holding period, low-phase threshold and cycle count.
- On run, the block writes each profile to the timer, starts it, waits for the timer-end pulse, then advances to the next profile.
- Sits between the host config bus and one PWM timer instance.

Parameters:
N_ENTRY, 4, number of profile entries (power of 2, at least 2)
IW, 2, index width, log2(N_ENTRY)
DW, 16, timer data width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cfg_we  in  1  profile-table write strobe
i_cfg_idx  in  IW  profile entry index
i_cfg_field  in  2  field select: 0=max (period), 1=pwm (low-phase threshold), 2=stop (cycle count); 3 is illegal
i_cfg_wdata  in  DW  field value
i_run  in  1  level; rising edge starts a sequence, low aborts it
i_loop  in  1  1 = wrap from last entry back to entry 0
i_last_idx  in  IW  last entry of the sequence
o_tmr_we  out  1  timer register write strobe
o_tmr_addr  out  2  timer register address (0/1/2, same map as i_cfg_field)
o_tmr_wdata  out  DW  timer register data
o_tmr_start  out  1  timer start level
i_tmr_end  in  1  timer end flag (multi-cycle high pulse)
o_busy  out  1  high in every state except IDLE
o_step_idx  out  IW  entry currently being executed
o_step_done  out  1  1-cycle pulse when an entry completes
o_seq_done  out  1  1-cycle pulse when a non-loop sequence completes
o_cfg_err  out  1  1-cycle pulse when a config write is rejected

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk.
  - Every output resets to 0; the FSM resets to IDLE.
  - Table contents are not reset; they are undefined until written.
- Config writes:
  - Accepted only in IDLE, when field < 3; the table is updated the next cycle.
  - A write while o_busy=1, or with field=3, is dropped and pulses o_cfg_err the cycle after.
- i_run rising edge is detected with a 1-flop edge register. In IDLE it:
  - samples i_last_idx and i_loop;
  - sets step_idx=0;
  - moves to CHECK.
- FSM states: IDLE, CHECK, LOAD, START, WAIT_END, WAIT_CLR, NEXT.
- CHECK (1 cycle):
  - if entry.max==0, the entry is skipped: go to NEXT with no writes, no start and no o_step_done;
  - otherwise go to LOAD.
- LOAD (exactly 3 cycles):
  - o_tmr_we=1 with addr 0, 1, 2 in consecutive cycles, wdata = entry max, pwm, stop respectively;
  - then go to START.
- START (1 cycle): o_tmr_start=1; go to WAIT_END.
- WAIT_END:
  - o_tmr_start held at 1;
  - on i_tmr_end=1, drop o_tmr_start the next cycle and go to WAIT_CLR.
- WAIT_CLR:
  - o_tmr_start=0;
  - on i_tmr_end=0, pulse o_step_done and go to NEXT.
- NEXT (1 cycle):
  - step_idx != last: step_idx+1, go to CHECK;
  - step_idx == last and loop=1: step_idx=0, go to CHECK;
  - step_idx == last and loop=0: pulse o_seq_done, go to IDLE.
- Latency: i_run rise at cycle t gives first o_tmr_we at t+2 (edge register, then CHECK) and o_tmr_start at t+5.
- Abort: i_run=0 in any non-IDLE state goes to IDLE the next cycle.
  - All timer outputs go to 0.
  - No done pulses are issued.
  - A LOAD in progress is truncated.
- The table is read only in CHECK/LOAD; there are no read/write hazards because writes are blocked while busy.
- i_tmr_end already high on entry to WAIT_END is treated as the end event.
- If every entry has max==0 and loop=1, the FSM cycles CHECK/NEXT without timer activity until aborted. This is legal.
- o_tmr_addr and o_tmr_wdata are 0 whenever o_tmr_we=0.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding localparams;
  - field/address constants: TMR_MAX=0, TMR_PWM=1, TMR_STOP=2;
  - DW.
- One sub-module, timer_prof_table: N_ENTRY x 3 x DW register file with a synchronous write port and a combinational read of the indexed entry. The FSM stays in timer_seq_ctrl.

Test Plan:
- Program entry0 = {max 10, pwm 4, stop 2}, last_idx=0, loop=0, raise i_run:
  - writes (0,10), (1,4), (2,2) on 3 consecutive cycles starting 2 cycles after the rise;
  - start is high on the 4th cycle after the first write;
  - model end high for 11 cycles: o_tmr_start falls 1 cycle after end rises;
  - o_step_done, then o_seq_done, 1 cycle apart after end falls; o_busy=0.
- Entries 0..3 valid, last_idx=3, loop=1: step_idx runs 0,1,2,3,0; o_seq_done never pulses; drop i_run in WAIT_END of entry 1 -> next cycle IDLE, start=0, no done pulse.
- Entry1.max=0, last_idx=2: entry 1 produces no o_tmr_we and no step_done; entries 0 and 2 execute; o_seq_done once.
- Config write while busy (idx 2, field 0, data 99): o_cfg_err pulses, table unchanged; field=3 write in IDLE also pulses o_cfg_err.
- Assert i_rst_n low during LOAD (2nd write cycle): all outputs 0 immediately; after release the FSM is in IDLE and needs a new i_run rise.
- i_tmr_end held high on entry to WAIT_END: immediate transition to WAIT_CLR, then waits for end low before o_step_done.
